// File: rtl/fir_stream_arbiter.sv
// Two-requester frame arbiter for a shared FIR with tag-based return routing; zero added latency on data beats, one grant cycle per frame.
// Backpressure passes straight through both paths, and a full tag FIFO holds new grants. FIR_ARB_FIXED_PRIORITY_EN selects fixed priority (requester 0 wins ties).

module fir_arb_tag_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  logic i_push_dat,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output logic o_head
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [DEPTH-1:0] r_mem;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB tells full from empty when the index bits match
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mem    <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
            r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end
endmodule

module fir_stream_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s0_axis_fir_tdata,
   input  logic                  s0_axis_fir_tvalid,
   input  logic                  s0_axis_fir_tlast,
   output logic                  s0_axis_fir_tready,
   input  logic [DATA_WIDTH-1:0] s1_axis_fir_tdata,
   input  logic                  s1_axis_fir_tvalid,
   input  logic                  s1_axis_fir_tlast,
   output logic                  s1_axis_fir_tready,
   output logic [DATA_WIDTH-1:0] fir_s_tdata,
   output logic                  fir_s_tvalid,
   output logic                  fir_s_tlast,
   input  logic                  fir_s_tready,
   input  logic [DATA_WIDTH-1:0] fir_m_tdata,
   input  logic                  fir_m_tvalid,
   input  logic                  fir_m_tlast,
   output logic                  fir_m_tready,
   output logic [DATA_WIDTH-1:0] m0_axis_fir_tdata,
   output logic                  m0_axis_fir_tvalid,
   output logic                  m0_axis_fir_tlast,
   input  logic                  m0_axis_fir_tready,
   output logic [DATA_WIDTH-1:0] m1_axis_fir_tdata,
   output logic                  m1_axis_fir_tvalid,
   output logic                  m1_axis_fir_tlast,
   input  logic                  m1_axis_fir_tready,
   output logic                  busy
);
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT0 = 2'd1,
      ST_GRANT1 = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_grant_vld;
   logic   w_grant_id;
   logic   w_frame_done;
   logic   w_tie_id;
   logic   w_tag_full;
   logic   w_tag_empty;
   logic   w_tag_head;
   logic   w_pop;
   logic   w_can_push;

`ifdef FIR_ARB_FIXED_PRIORITY_EN
   assign w_tie_id = 1'b0;
`else
   logic r_last_srv;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_last_srv <= 1'b1;
      end else if (w_frame_done) begin
         r_last_srv <= (r_state == ST_GRANT1);
      end
   end

   assign w_tie_id = ~r_last_srv;
`endif

   // A pop in the same cycle frees the slot a new grant needs
   assign w_can_push = !w_tag_full || w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_grant_vld        = 1'b0;
      w_grant_id         = 1'b0;
      w_frame_done       = 1'b0;
      s0_axis_fir_tready = 1'b0;
      s1_axis_fir_tready = 1'b0;
      fir_s_tdata        = '0;
      fir_s_tvalid       = 1'b0;
      fir_s_tlast        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((s0_axis_fir_tvalid || s1_axis_fir_tvalid) && w_can_push) begin
               w_grant_vld = 1'b1;
               w_grant_id  = (s0_axis_fir_tvalid && s1_axis_fir_tvalid) ? w_tie_id : !s0_axis_fir_tvalid;
               w_state_nxt = w_grant_id ? ST_GRANT1 : ST_GRANT0;
            end
         end
         ST_GRANT0: begin
            fir_s_tdata        = s0_axis_fir_tdata;
            fir_s_tvalid       = s0_axis_fir_tvalid;
            fir_s_tlast        = s0_axis_fir_tlast;
            s0_axis_fir_tready = fir_s_tready;
            if (s0_axis_fir_tvalid && fir_s_tready && s0_axis_fir_tlast) begin
               w_frame_done = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_GRANT1: begin
            fir_s_tdata        = s1_axis_fir_tdata;
            fir_s_tvalid       = s1_axis_fir_tvalid;
            fir_s_tlast        = s1_axis_fir_tlast;
            s1_axis_fir_tready = fir_s_tready;
            if (s1_axis_fir_tvalid && fir_s_tready && s1_axis_fir_tlast) begin
               w_frame_done = 1'b1;
               w_state_nxt  = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   fir_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_grant_vld),
      .i_push_dat (w_grant_id),
      .i_pop      (w_pop),
      .o_full     (w_tag_full),
      .o_empty    (w_tag_empty),
      .o_head     (w_tag_head)
   );

   // Head tag names the requester whose frame is leaving the FIR
   assign fir_m_tready       = !w_tag_empty && (w_tag_head ? m1_axis_fir_tready : m0_axis_fir_tready);
   assign w_pop              = fir_m_tvalid && fir_m_tready && fir_m_tlast;
   assign m0_axis_fir_tdata  = fir_m_tdata;
   assign m0_axis_fir_tlast  = fir_m_tlast;
   assign m0_axis_fir_tvalid = fir_m_tvalid && !w_tag_empty && !w_tag_head;
   assign m1_axis_fir_tdata  = fir_m_tdata;
   assign m1_axis_fir_tlast  = fir_m_tlast;
   assign m1_axis_fir_tvalid = fir_m_tvalid && !w_tag_empty && w_tag_head;

   assign busy = (r_state != ST_IDLE);
endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Randomized bench: frame-level reference model (owner order, per-requester streams, FIR loopback) plus directed corner cases.
module tb_fir_stream_arbiter;
   localparam int DW = 16;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] s0_axis_fir_tdata, s1_axis_fir_tdata, fir_s_tdata, fir_m_tdata;
   logic [DW-1:0] m0_axis_fir_tdata, m1_axis_fir_tdata;
   logic          s0_axis_fir_tvalid, s0_axis_fir_tlast, s0_axis_fir_tready;
   logic          s1_axis_fir_tvalid, s1_axis_fir_tlast, s1_axis_fir_tready;
   logic          fir_s_tvalid, fir_s_tlast, fir_s_tready;
   logic          fir_m_tvalid, fir_m_tlast, fir_m_tready;
   logic          m0_axis_fir_tvalid, m0_axis_fir_tlast, m0_axis_fir_tready;
   logic          m1_axis_fir_tvalid, m1_axis_fir_tlast, m1_axis_fir_tready;
   logic          busy;

   always #5 clk = ~clk;

   fir_stream_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset(reset),
      .s0_axis_fir_tdata(s0_axis_fir_tdata), .s0_axis_fir_tvalid(s0_axis_fir_tvalid),
      .s0_axis_fir_tlast(s0_axis_fir_tlast), .s0_axis_fir_tready(s0_axis_fir_tready),
      .s1_axis_fir_tdata(s1_axis_fir_tdata), .s1_axis_fir_tvalid(s1_axis_fir_tvalid),
      .s1_axis_fir_tlast(s1_axis_fir_tlast), .s1_axis_fir_tready(s1_axis_fir_tready),
      .fir_s_tdata(fir_s_tdata), .fir_s_tvalid(fir_s_tvalid),
      .fir_s_tlast(fir_s_tlast), .fir_s_tready(fir_s_tready),
      .fir_m_tdata(fir_m_tdata), .fir_m_tvalid(fir_m_tvalid),
      .fir_m_tlast(fir_m_tlast), .fir_m_tready(fir_m_tready),
      .m0_axis_fir_tdata(m0_axis_fir_tdata), .m0_axis_fir_tvalid(m0_axis_fir_tvalid),
      .m0_axis_fir_tlast(m0_axis_fir_tlast), .m0_axis_fir_tready(m0_axis_fir_tready),
      .m1_axis_fir_tdata(m1_axis_fir_tdata), .m1_axis_fir_tvalid(m1_axis_fir_tvalid),
      .m1_axis_fir_tlast(m1_axis_fir_tlast), .m1_axis_fir_tready(m1_axis_fir_tready),
      .busy(busy)
   );

   typedef struct { logic [DW-1:0] d; logic l; } beat_t;
   typedef struct { logic [DW-1:0] d; logic l; int t; } pbeat_t;

   beat_t  drv_q[2][$];
   beat_t  exp_q[2][$];
   pbeat_t pipe[$];
   int     tagq[$];
   int     starts[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int n_starts = 0;
   int first_m_cyc = -1;
   int rel_cyc = 0;
   int own = 0;
   int prev = 1;
   int nf[2];
   int gap[2];
   int gapset[2];
   bit sof[2];
   bit vld[2];
   bit xf[2];
   bit in_frame = 1'b0;
   bit post_rst_chk = 1'b0;
   int gap_max = 0;
   int fr_pct = 100;
   int m_pct = 100;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic load_frame(input int src, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = {src[0], 15'($urandom)};
         b.l = (i == len - 1);
         drv_q[src].push_back(b);
         exp_q[src].push_back(b);
      end
      nf[src]++;
   endtask

   // Owner of the next frame, from the frames still waiting on each side
   function automatic int exp_owner();
`ifdef FIR_ARB_FIXED_PRIORITY_EN
      return (nf[0] > 0) ? 0 : 1;
`else
      return (nf[1-prev] > 0) ? 1 - prev : prev;
`endif
   endfunction

   task automatic flush();
      for (int x = 0; x < 2; x++) begin
         drv_q[x].delete();
         exp_q[x].delete();
         nf[x] = 0; sof[x] = 1'b1; vld[x] = 1'b0; xf[x] = 1'b0; gap[x] = 0;
      end
      pipe.delete();
      tagq.delete();
      in_frame = 1'b0;
      prev = 1;
   endtask

   task automatic drive();
      cyc++;
      for (int x = 0; x < 2; x++) begin
         if (drv_q[x].size() == 0) vld[x] = 1'b0;
         else if (vld[x] && !xf[x]) vld[x] = 1'b1;
         else if (sof[x]) vld[x] = 1'b1;
         else if (gap[x] > 0) begin gap[x]--; vld[x] = 1'b0; end
         else vld[x] = 1'b1;
         xf[x] = 1'b0;
      end
      s0_axis_fir_tvalid = vld[0];
      s0_axis_fir_tdata  = (drv_q[0].size() != 0) ? drv_q[0][0].d : '0;
      s0_axis_fir_tlast  = (drv_q[0].size() != 0) ? drv_q[0][0].l : 1'b0;
      s1_axis_fir_tvalid = vld[1];
      s1_axis_fir_tdata  = (drv_q[1].size() != 0) ? drv_q[1][0].d : '0;
      s1_axis_fir_tlast  = (drv_q[1].size() != 0) ? drv_q[1][0].l : 1'b0;
      fir_s_tready       = (int'($urandom_range(0, 99)) < fr_pct);
      m0_axis_fir_tready = (int'($urandom_range(0, 99)) < m_pct);
      m1_axis_fir_tready = (int'($urandom_range(0, 99)) < m_pct);
      if (pipe.size() != 0 && pipe[0].t <= cyc) begin
         fir_m_tvalid = 1'b1; fir_m_tdata = pipe[0].d; fir_m_tlast = pipe[0].l;
      end else begin
         fir_m_tvalid = 1'b0; fir_m_tdata = '0; fir_m_tlast = 1'b0;
      end
   endtask

   task automatic monitor();
      bit     s0x, s1x, fx, fmx;
      bit     mx[2];
      beat_t  b;
      pbeat_t p;
      s0x   = s0_axis_fir_tvalid && s0_axis_fir_tready;
      s1x   = s1_axis_fir_tvalid && s1_axis_fir_tready;
      fx    = fir_s_tvalid && fir_s_tready;
      fmx   = fir_m_tvalid && fir_m_tready;
      mx[0] = m0_axis_fir_tvalid && m0_axis_fir_tready;
      mx[1] = m1_axis_fir_tvalid && m1_axis_fir_tready;
      if (post_rst_chk) begin
         post_rst_chk = 1'b0;
         rel_cyc = cyc;
         chk("post_reset_outputs", 32'({busy, s0_axis_fir_tready, s1_axis_fir_tready, fir_s_tvalid,
                                        fir_m_tready, m0_axis_fir_tvalid, m1_axis_fir_tvalid}), 0);
      end
      chk("tready_exclusive", 32'(s0_axis_fir_tready & s1_axis_fir_tready), 0);
      if (in_frame) chk("nonowner_tready", 32'(own != 0 ? s0_axis_fir_tready : s1_axis_fir_tready), 0);
      if (fx) begin
         if (!in_frame) begin
            own = exp_owner();
            nf[own]--;
            in_frame = 1'b1;
            tagq.push_back(own);
            starts.push_back(cyc);
            n_starts++;
         end
         chk("grant_owner", 32'({s1x, s0x}), (own != 0) ? 2 : 1);
         if (drv_q[own].size() == 0) begin
            chk("fir_s_unexpected_beat", 1, 0);
         end else begin
            b = drv_q[own].pop_front();
            chk("fir_s_beat", 32'({fir_s_tlast, fir_s_tdata}), 32'({b.l, b.d}));
            xf[own] = 1'b1;
            if (b.l) begin
               sof[own] = 1'b1; in_frame = 1'b0; prev = own;
            end else begin
               sof[own] = 1'b0;
               gap[own] = (gapset[own] >= 0) ? gapset[own] : int'($urandom_range(0, gap_max));
            end
            p.d = fir_s_tdata; p.l = fir_s_tlast; p.t = cyc + 2;
            pipe.push_back(p);
         end
      end else begin
         chk("src_xfer_without_fir", 32'({s1x, s0x}), 0);
      end
      if (fmx) begin
         if (first_m_cyc < 0) first_m_cyc = cyc;
         if (pipe.size() != 0) p = pipe.pop_front();
         if (tagq.size() == 0) begin
            chk("route_without_tag", 1, 0);
         end else begin
            chk("route", 32'({mx[1], mx[0]}), (tagq[0] != 0) ? 2 : 1);
            if (fir_m_tlast) void'(tagq.pop_front());
         end
      end else begin
         chk("m_xfer_without_fir", 32'({mx[1], mx[0]}), 0);
      end
      for (int x = 0; x < 2; x++) begin
         if (mx[x]) begin
            if (exp_q[x].size() == 0) begin
               chk("m_unexpected_beat", 1, 0);
            end else begin
               b = exp_q[x].pop_front();
               chk(x == 0 ? "m0_beat" : "m1_beat",
                   32'(x == 0 ? {m0_axis_fir_tlast, m0_axis_fir_tdata} : {m1_axis_fir_tlast, m1_axis_fir_tdata}),
                   32'({b.l, b.d}));
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (!reset) monitor();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((drv_q[0].size() != 0 || drv_q[1].size() != 0 || pipe.size() != 0 ||
              exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_in_budget", 32'(n < budget), 1);
   endtask

   initial begin
      int base;
      int n;
      int n0, n1;
      reset = 1'b1;
      gapset[0] = -1;
      gapset[1] = -1;
      flush();

      // Tie at reset release, 3-beat frames, 2-cycle loopback
      load_frame(0, 3);
      load_frame(1, 3);
      drive();
      repeat (3) tick();
      reset = 1'b0;
      post_rst_chk = 1'b1;
      drain(200);
      if (starts.size() != 0) chk("first_beat_after_grant", starts[0] - rel_cyc, 1);
      else chk("first_frame_seen", 0, 1);

      // Mid-frame 5-cycle valid gap on s0 while s1 waits
      gapset[0] = 5;
      load_frame(0, 3);
      load_frame(1, 1);
      drain(200);
      gapset[0] = -1;

      // FIR output stalled with five single-beat frames offered
      m_pct = 0;
      base = n_starts;
      for (int i = 0; i < 3; i++) load_frame(0, 1);
      for (int i = 0; i < 2; i++) load_frame(1, 1);
      repeat (20) tick();
      chk("grants_while_stalled", n_starts - base, TD);
      chk("busy_while_stalled", 32'(busy), 0);
      m_pct = 100;
      first_m_cyc = -1;
      drain(200);
      if (starts.size() > base + 4) chk("regrant_after_pop", starts[base+4] - first_m_cyc, 1);
      else chk("fifth_grant_seen", 0, 1);

      // Reset in the second beat of an s1 frame, right after s0 was served
      load_frame(0, 1);
      drain(100);
      gapset[1] = 0;
      load_frame(1, 3);
      n = 0;
      while (!(in_frame && drv_q[1].size() == 2) && n < 50) begin
         tick();
         n++;
      end
      chk("s1_midframe_reached", 32'(n < 50), 1);
      gapset[1] = -1;
      reset = 1'b1;
      flush();
      load_frame(0, 2);
      load_frame(1, 2);
      drive();
      tick();
      reset = 1'b0;
      post_rst_chk = 1'b1;
      drain(200);

      // Randomized rounds
      for (int r = 0; r < 14; r++) begin
         fr_pct  = $urandom_range(40, 100);
         m_pct   = $urandom_range(20, 100);
         gap_max = $urandom_range(0, 3);
         n0 = $urandom_range(0, 4);
         n1 = $urandom_range(0, 4);
         if (n0 + n1 == 0) n0 = 1;
         for (int i = 0; i < n0; i++) load_frame(0, $urandom_range(1, 4));
         for (int i = 0; i < n1; i++) load_frame(1, $urandom_range(1, 4));
         drain(3000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fir_stream_arbiter.md
FIR_STREAM_ARBITER -- requirements
Module: fir_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, sample width of all tdata buses.
REQ-002 Parameter TAG_DEPTH, default 4, number of frames that may be outstanding inside the FIR (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s0_axis_fir_tdata / tvalid / tlast  input  DATA_WIDTH/1/1  requester 0 sample stream; s0_axis_fir_tready  output  1.
REQ-006 s1_axis_fir_tdata / tvalid / tlast  input  DATA_WIDTH/1/1  requester 1 sample stream; s1_axis_fir_tready  output  1.
REQ-007 fir_s_tdata / tvalid / tlast  output  DATA_WIDTH/1/1  stream into the shared FIR; fir_s_tready  input  1.
REQ-008 fir_m_tdata / tvalid / tlast  input  DATA_WIDTH/1/1  stream out of the shared FIR; fir_m_tready  output  1.
REQ-009 m0_axis_fir_tdata / tvalid / tlast  output  DATA_WIDTH/1/1  filtered results for requester 0; m0_axis_fir_tready  input  1.
REQ-010 m1_axis_fir_tdata / tvalid / tlast  output  DATA_WIDTH/1/1  filtered results for requester 1; m1_axis_fir_tready  input  1.
REQ-011 busy  output  1  high when state is not IDLE.

Function
REQ-012 Input FSM states: IDLE, GRANT0, GRANT1. A beat transfers when tvalid and tready are both high.
REQ-013 IDLE: all sX tready low and fir_s_tvalid low. Grant is evaluated when at least one sX tvalid is high and the tag FIFO is not full.
REQ-014 Grant rule: a single requester wins. If both request, the requester not served last wins (round-robin). The move to GRANTx takes one cycle, and the owner ID x is pushed into the tag FIFO on that same edge.
REQ-015 GRANTx: combinational pass-through. fir_s_tdata/tvalid/tlast equal sx. sx_tready equals fir_s_tready. The other requester's tready is low.
REQ-016 GRANTx returns to IDLE on the edge where the sx beat with tlast=1 transfers; the last-served pointer updates to x on that edge.
REQ-017 Arbitration is frame-granular. No interleaving is permitted between tlast boundaries, even if sx tvalid drops mid-frame.
REQ-018 Tag FIFO: TAG_DEPTH entries, 1 bit each, with full and empty flags and a wrap-around read/write pointer. When full, no new grant is issued; the current frame continues.
REQ-019 Output routing: while the tag FIFO is non-empty, head tag h selects the destination. mh tdata/tvalid/tlast equal fir_m, fir_m_tready equals mh_tready, and the other m tvalid is low.
REQ-020 While the tag FIFO is empty, fir_m_tready is low and both m tvalid outputs are low.
REQ-021 The head tag pops on the edge where a fir_m beat with tlast=1 transfers.
REQ-022 A push and a pop in the same cycle are both performed and the occupancy is unchanged. A push is permitted while full only if a pop occurs that cycle; otherwise it waits.
REQ-023 Latency: zero added cycles on data beats. Frame start has one grant cycle of overhead from IDLE.
REQ-024 The block never modifies tdata; width and sign are passed unchanged.

Reset
REQ-025 On reset: state IDLE, tag FIFO emptied (pointers 0), last-served pointer set to 1 so requester 0 wins the first tie, busy=0.
REQ-026 Reset asserted mid-frame aborts the frame and flushes outstanding tags. Every tready and tvalid output is low in the cycle following reset.

Configuration
REQ-027 Macro FIR_ARB_FIXED_PRIORITY_EN: when defined, ties are always won by requester 0 and the last-served pointer is unused. When undefined, round-robin per REQ-014 applies.

Verification
REQ-028 Both requesters valid at reset release, 3-beat frames, fir loopback with 2-cycle delay -> s0 frame first, then s1; results appear on m0 then m1 with tlast on beat 3.
REQ-029 s0 frame with s0 tvalid low for 5 cycles mid-frame while s1 is valid -> s1_tready stays low until the s0 tlast transfer.
REQ-030 FIR output stalled, 5 single-beat frames offered (TAG_DEPTH=4) -> 4 grants, 5th withheld until the first fir_m tlast pops.
REQ-031 Tag FIFO full, with fir_m tlast transfer and a new request in the same cycle -> pop, then the next grant proceeds; occupancy returns to 4.
REQ-032 Reset asserted during the second beat of an s1 frame -> next cycle busy=0, all tready/tvalid low, and a subsequent tie is granted to s0.
REQ-033 With FIR_ARB_FIXED_PRIORITY_EN defined, back-to-back requests on both channels -> s0 wins every tie, and s1 is granted only when s0 tvalid is low in IDLE.
